fpalu_divider: RTL and testbench
================================

Name: fpalu_divider

Overview:
- Iterative IEEE-754 single-precision divider (Quotient = A / B); the inverse operation to the combinational fpalu multiplier.
- Sits beside the fpalu add/multiply units and is driven by the same controller through a start/done handshake.
- Uses one quotient bit per cycle (restoring division) to keep area small.
- Round-to-nearest-even; subnormals are flushed to zero.

Parameters:
- QBITS, 26, quotient bits generated (1 integer + 25 fraction: 23 mantissa + guard + round); legal values ≥ 26.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- A  input  32  dividend, IEEE-754 single.
- B  input  32  divisor, IEEE-754 single.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when Quotient and flags are valid.
- Quotient  output  32  result; held until the next accepted start.
- overflow  output  1  result exponent overflowed to infinity.
- underflow  output  1  result flushed to zero by exponent underflow.
- div_by_zero  output  1  finite nonzero / zero.

Behaviour:
- Reset: reset=0 at a rising edge forces the following on the next cycle.
  - State returns to IDLE.
  - busy, done, overflow, underflow and div_by_zero go to 0; Quotient goes to 32'h0.
  - This applies even mid-operation; the in-flight result is discarded.
- States: IDLE, DIVIDE, ROUND, DONE.
- IDLE:
  - On start=1 at edge T, A and B are captured and unpacked. Exponent 0 is treated as zero.
  - A special case goes to ROUND with a special flag set; otherwise the block goes to DIVIDE with count=0.
  - busy=1 from T+1.
- DIVIDE:
  - Remainder initialised to the dividend mantissa {1,fracA}; divisor is {1,fracB} (24b).
  - Each cycle: if rem ≥ div, then rem -= div and the quotient bit is 1.
  - Then rem <<= 1 and the quotient shifts left.
  - Exits to ROUND after QBITS cycles (T+1..T+26).
- ROUND (T+27, specials at T+1):
  - Normalise: if the quotient integer bit is 0, shift left 1 and subtract 1 from the exponent.
  - Exponent = eA − eB + 127 (10-bit signed arithmetic), adjusted by normalisation.
  - Guard = first bit below the LSB; sticky = OR of the remaining quotient bits and (rem≠0).
  - RNE: increment if guard & (sticky | LSB).
  - A mantissa carry-out increments the exponent.
  - Exponent ≥ 255 gives signed infinity with overflow=1. Exponent ≤ 0 gives signed zero with underflow=1.
- DONE (T+28 normal, T+2 special):
  - Quotient and flags are registered; done=1 for exactly one cycle; busy=0.
  - Next cycle returns to IDLE.
- Special cases (sign = signA ^ signB except NaN):
  - Any NaN, 0/0 or inf/inf gives 32'h7FC00000.
  - inf/finite gives signed infinity.
  - finite/inf gives signed zero.
  - 0/nonzero gives signed zero.
  - nonzero finite/0 gives signed infinity with div_by_zero=1.
- Flags clear on every accepted start; only the flags of the latest operation are visible.
- start while busy (DIVIDE/ROUND/DONE) is ignored and not queued.
- start in the cycle after done is accepted, since the block is in IDLE then.
- A/B may change after the start edge without effect.

Decomposition:
- Package fpalu_pkg:
  - Field widths: EXP_W=8, FRAC_W=23.
  - BIAS=127.
  - QNAN=32'h7FC00000, POS_INF=32'h7F800000.
  - State encoding for IDLE/DIVIDE/ROUND/DONE.
  - Classify helper constants for zero/inf/NaN.
- One sub-module, fpalu_mant_div:
  - Contains the iterative restoring mantissa divider: remainder/quotient registers and the bit counter.
  - Handshake is load/busy/valid, plus a remainder-nonzero output.
  - fpalu_divider keeps unpack, special-case handling, exponent logic, rounding and the FSM.

Test Plan:
- A=0x40C00000 (6.0), B=0x40000000 (2.0), start at T -> busy T+1..T+27, done at T+28, Quotient=0x40400000, all flags 0.
- A=0xBF800000 (-1.0), B=0x40400000 (3.0) -> Quotient=0xBEAAAAAB (RNE round-up checked), done at T+28.
- A=0x3F800000, B=0x00000000 -> done at T+2, Quotient=0x7F800000, div_by_zero=1; then A=B=0 -> 0x7FC00000, div_by_zero=0.
- A=0x7F7FFFFF, B=0x3F000000 (0.5) -> Quotient=0x7F800000, overflow=1; A=0x00800000, B=0x4B000000 -> Quotient=0x00000000, underflow=1.
- Mid-operation checks on an operation started with 6.0/2.0:
  - Pulse start again at T+10 -> ignored; the result is still 0x40400000.
  - Drive reset=0 at T+15 -> all outputs 0 the next cycle, no done pulse.
  - After reset release, a new start completes normally.
- Back-to-back: start in the cycle after done -> accepted; second done exactly 29 cycles after the first done's start.

Source files
------------

// File: rtl/fpalu_divider_pkg.sv
// fpalu_pkg: shared definitions for the fpalu divider.
//   - IEEE-754 single-precision field widths, bias and special encodings
//   - Controller state encoding
//   - Operand classification (zero / normal / inf / NaN) with subnormals flushed to zero
package fpalu_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned MANT_W = FRAC_W + 1;  // hidden bit included
    localparam int unsigned BIAS   = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    // Classification exponent codes
    localparam logic [EXP_W-1:0] EXP_ZERO = '0;  // zero, or a subnormal that is flushed
    localparam logic [EXP_W-1:0] EXP_ONES = '1;  // infinity or NaN

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDivide = 2'd1,
        StRound  = 2'd2,
        StDone   = 2'd3
    } div_state_e;

    typedef enum logic [1:0] {
        ClsZero   = 2'd0,
        ClsNormal = 2'd1,
        ClsInf    = 2'd2,
        ClsNan    = 2'd3
    } fp_class_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  expo;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    function automatic fp_class_e classify(input fp32_t x);
        fp_class_e cls;
        if (x.expo == EXP_ZERO) begin
            cls = ClsZero;
        end else if (x.expo != EXP_ONES) begin
            cls = ClsNormal;
        end else if (x.frac == '0) begin
            cls = ClsInf;
        end else begin
            cls = ClsNan;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fpalu_divider_if.sv
// fpalu_divider_if: controller <-> divider handshake and data bus.
//   start        controller request, sampled by the divider only while idle
//   A, B         dividend / divisor (IEEE-754 single)
//   busy, done   operation in flight / one-cycle completion pulse
//   Quotient     result, held until replaced by a later operation
//   overflow, underflow, div_by_zero  exception flags of the latest operation
// master = controller side, slave = divider side.
interface fpalu_divider_if;

    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] Quotient;
    logic        overflow;
    logic        underflow;
    logic        div_by_zero;

    modport master (
        output start, A, B,
        input  busy, done, Quotient, overflow, underflow, div_by_zero
    );

    modport slave (
        input  start, A, B,
        output busy, done, Quotient, overflow, underflow, div_by_zero
    );

endinterface

// File: rtl/fpalu_mant_div.sv
// fpalu_mant_div: iterative restoring mantissa divider, one quotient bit per cycle.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-low reset
//   load           capture dividend/divisor and start a new division
//   dividend       {1, fracA}
//   divisor        {1, fracB}
//   busy           iterations in progress
//   last           final iteration is being performed this cycle
//   valid          quotient/remainder complete, held until the next load
//   quotient       QBITS quotient bits, MSB is the integer bit
//   rem_nz         final remainder is nonzero (feeds the sticky bit)
module fpalu_mant_div
    import fpalu_pkg::*;
#(
    parameter int unsigned QBITS = 26
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [MANT_W-1:0] dividend,
    input  logic [MANT_W-1:0] divisor,
    output logic              busy,
    output logic              last,
    output logic              valid,
    output logic [QBITS-1:0]  quotient,
    output logic              rem_nz
);

    localparam int unsigned CNT_W = $clog2(QBITS);

    // One bit wider than the divisor: after the shift the remainder is < 2*divisor.
    logic [MANT_W:0]   rem_q;
    logic [MANT_W-1:0] div_q;
    logic [QBITS-1:0]  quo_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              valid_q;

    logic              ge;
    logic [MANT_W-1:0] rem_sub;

    // After a restoring step the remainder is always below the divisor, so it fits MANT_W bits.
    always_comb begin
        ge      = rem_q >= {1'b0, div_q};
        rem_sub = ge ? MANT_W'(rem_q - {1'b0, div_q}) : rem_q[MANT_W-1:0];
    end

    assign last = busy_q && (cnt_q == CNT_W'(QBITS - 1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            rem_q   <= '0;
            div_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (load) begin
            rem_q   <= {1'b0, dividend};
            div_q   <= divisor;
            quo_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
        end else if (busy_q) begin
            rem_q <= {rem_sub, 1'b0};
            quo_q <= {quo_q[QBITS-2:0], ge};
            cnt_q <= cnt_q + CNT_W'(1);
            if (last) begin
                busy_q  <= 1'b0;
                valid_q <= 1'b1;
            end
        end
    end

    assign busy     = busy_q;
    assign valid    = valid_q;
    assign quotient = quo_q;
    assign rem_nz   = |rem_q;

endmodule

// File: rtl/fpalu_divider.sv
// fpalu_divider: iterative IEEE-754 single-precision divider, Quotient = A / B.
// Round-to-nearest-even, subnormal inputs and results flushed to zero.
// Ports:
//   clock   rising-edge clock
//   reset   synchronous active-low reset; aborts any operation in flight
//   bus     fpalu_divider_if.slave: start, A, B in; busy, done, Quotient,
//           overflow, underflow, div_by_zero out (all outputs registered)
// Latency from the accepting edge: done 28 cycles later for a real division,
// 2 cycles later for special operands.
module fpalu_divider
    import fpalu_pkg::*;
#(
    parameter int unsigned QBITS = 26
) (
    input  logic           clock,
    input  logic           reset,
    fpalu_divider_if.slave bus
);

    // ---------------------------------------------------------------- unpack
    fp32_t            op_a;
    fp32_t            op_b;
    fp_class_e        cls_a;
    fp_class_e        cls_b;
    logic             sign_in;
    logic signed [9:0] exp_in;

    assign op_a    = bus.A;
    assign op_b    = bus.B;
    assign cls_a   = classify(op_a);
    assign cls_b   = classify(op_b);
    assign sign_in = op_a.sign ^ op_b.sign;
    assign exp_in  = 10'(op_a.expo) - 10'(op_b.expo) + 10'(BIAS);

    // --------------------------------------------------------- special cases
    logic        spec_hit;
    logic [31:0] spec_res;
    logic        spec_dbz;

    always_comb begin
        spec_hit = 1'b1;
        spec_res = QNAN;
        spec_dbz = 1'b0;
        if (cls_a == ClsNan || cls_b == ClsNan ||
            (cls_a == ClsZero && cls_b == ClsZero) ||
            (cls_a == ClsInf && cls_b == ClsInf)) begin
            spec_res = QNAN;
        end else if (cls_a == ClsInf) begin
            spec_res = {sign_in, POS_INF[30:0]};
        end else if (cls_b == ClsInf || cls_a == ClsZero) begin
            spec_res = {sign_in, 31'b0};
        end else if (cls_b == ClsZero) begin
            spec_res = {sign_in, POS_INF[30:0]};
            spec_dbz = 1'b1;
        end else begin
            spec_hit = 1'b0;
        end
    end

    // ------------------------------------------------------ mantissa divider
    div_state_e       state_q;
    logic             load;
    logic             mant_busy;
    logic             mant_last;
    logic             mant_valid;
    logic [QBITS-1:0] mant_quo;
    logic             mant_rem_nz;

    assign load = (state_q == StIdle) && bus.start && !spec_hit;

    fpalu_mant_div #(
        .QBITS (QBITS)
    ) u_mant_div (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .dividend ({1'b1, op_a.frac}),
        .divisor  ({1'b1, op_b.frac}),
        .busy     (mant_busy),
        .last     (mant_last),
        .valid    (mant_valid),
        .quotient (mant_quo),
        .rem_nz   (mant_rem_nz)
    );

    // ------------------------------------------------- normalise and round
    logic              sign_q;
    logic signed [9:0] exp_q;

    logic              norm_shift;
    logic [QBITS-1:0]  q_norm;
    logic [MANT_W-1:0] mant;
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [MANT_W:0]   mant_rnd;
    logic              carry;
    logic [FRAC_W-1:0] frac_out;
    logic signed [9:0] exp_rnd;
    logic [31:0]       rnd_result;
    logic              rnd_ovf;
    logic              rnd_unf;

    always_comb begin
        // Quotient of two [1,2) mantissas lies in (0.5,2): at most one left shift.
        norm_shift = ~mant_quo[QBITS-1];
        q_norm     = norm_shift ? {mant_quo[QBITS-2:0], 1'b0} : mant_quo;
        mant       = q_norm[QBITS-1 -: MANT_W];
        guard      = q_norm[QBITS-1-MANT_W];
        sticky     = (|q_norm[QBITS-2-MANT_W:0]) | mant_rem_nz;
        round_up   = guard & (sticky | mant[0]);
        mant_rnd   = {1'b0, mant} + {{MANT_W{1'b0}}, round_up};
        carry      = mant_rnd[MANT_W];
        // On carry-out the mantissa is exactly 2.0, i.e. 1.0 with the exponent bumped.
        frac_out   = carry ? mant_rnd[MANT_W-1:1] : mant_rnd[FRAC_W-1:0];
        exp_rnd    = exp_q - (norm_shift ? 10'sd1 : 10'sd0) + (carry ? 10'sd1 : 10'sd0);

        rnd_ovf    = 1'b0;
        rnd_unf    = 1'b0;
        if (exp_rnd >= 10'sd255) begin
            rnd_result = {sign_q, POS_INF[30:0]};
            rnd_ovf    = 1'b1;
        end else if (exp_rnd <= 10'sd0) begin
            rnd_result = {sign_q, 31'b0};
            rnd_unf    = 1'b1;
        end else begin
            rnd_result = {sign_q, exp_rnd[EXP_W-1:0], frac_out};
        end
    end

    // --------------------------------------------------------------- control
    logic        special_q;
    logic [31:0] spec_res_q;
    logic        spec_dbz_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] quotient_q;
    logic        ovf_q;
    logic        unf_q;
    logic        dbz_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= StIdle;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            spec_dbz_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            quotient_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        busy_q     <= 1'b1;
                        ovf_q      <= 1'b0;
                        unf_q      <= 1'b0;
                        dbz_q      <= 1'b0;
                        sign_q     <= sign_in;
                        exp_q      <= exp_in;
                        special_q  <= spec_hit;
                        spec_res_q <= spec_res;
                        spec_dbz_q <= spec_dbz;
                        state_q    <= spec_hit ? StRound : StDivide;
                    end
                end
                StDivide: begin
                    if (mant_last) begin
                        state_q <= StRound;
                    end
                end
                StRound: begin
                    if (special_q) begin
                        quotient_q <= spec_res_q;
                        dbz_q      <= spec_dbz_q;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= StDone;
                    end else if (mant_valid && !mant_busy) begin
                        quotient_q <= rnd_result;
                        ovf_q      <= rnd_ovf;
                        unf_q      <= rnd_unf;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.Quotient    = quotient_q;
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = unf_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_fpalu_divider.sv
// Directed bench for fpalu_divider: a table of operand pairs with hand-computed
// results, flags and latencies, followed by hand-written multi-cycle sequences
// (stray start while busy, mid-operation reset, back-to-back operations, flag clearing).
module tb_fpalu_divider;

    localparam int TIMEOUT = 100;
    localparam int NVEC    = 19;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    fpalu_divider_if bus ();

    fpalu_divider #(
        .QBITS (26)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [2:0]  flags;  // {overflow, underflow, div_by_zero}
        int          lat;
    } vec_t;

    vec_t vecs [NVEC];

    int checks = 0;
    int errors = 0;
    int lat;
    int n;
    bit busy_bad;
    bit seen_done;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Advance until done is seen or the cycle budget runs out.
    task automatic wait_done(inout int cnt);
        while (!bus.done && cnt < TIMEOUT) begin
            @(posedge clock);
            #1;
            cnt++;
        end
    endtask

    // Called #1 after a rising edge with the DUT idle; returns in the done cycle.
    // cyc counts edges from the accepting edge (1) to the edge that raised done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output bit bad);
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.A     = 32'hDEAD_BEEF;  // operands must already be captured
        bus.B     = 32'h0BAD_F00D;
        cyc       = 1;
        bad       = 1'b0;
        while (!bus.done && cyc < TIMEOUT) begin
            if (!bus.busy) bad = 1'b1;
            @(posedge clock);
            #1;
            cyc++;
        end
        if (bus.busy) bad = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, 28}; // 6/2
        vecs[1]  = '{32'hBF80_0000, 32'h4040_0000, 32'hBEAA_AAAB, 3'b000, 28}; // -1/3 rounds up
        vecs[2]  = '{32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 3'b001, 2};  // 1/0
        vecs[3]  = '{32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b000, 2};  // 0/0
        vecs[4]  = '{32'h7F7F_FFFF, 32'h3F00_0000, 32'h7F80_0000, 3'b100, 28}; // max/0.5
        vecs[5]  = '{32'h0080_0000, 32'h4B00_0000, 32'h0000_0000, 3'b010, 28}; // min/2^23
        vecs[6]  = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 3'b000, 28}; // 1/1
        vecs[7]  = '{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 3'b000, 28}; // 1/3
        vecs[8]  = '{32'h4040_0000, 32'h4000_0000, 32'h3FC0_0000, 3'b000, 28}; // 3/2
        vecs[9]  = '{32'h4000_0000, 32'hC080_0000, 32'hBF00_0000, 3'b000, 28}; // 2/-4
        vecs[10] = '{32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 3'b000, 2};  // inf/2
        vecs[11] = '{32'hC040_0000, 32'h7F80_0000, 32'h8000_0000, 3'b000, 2};  // -3/inf
        vecs[12] = '{32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 3'b000, 2};  // NaN/1
        vecs[13] = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 3'b000, 2};  // inf/-inf
        vecs[14] = '{32'h8000_0000, 32'h40A0_0000, 32'h8000_0000, 3'b000, 2};  // -0/5
        vecs[15] = '{32'h3F80_0000, 32'h8000_0000, 32'hFF80_0000, 3'b001, 2};  // 1/-0
        vecs[16] = '{32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 3'b000, 2};  // subnormal/1
        vecs[17] = '{32'h7F80_0000, 32'h0000_0000, 32'h7F80_0000, 3'b000, 2};  // inf/0
        vecs[18] = '{32'h3F80_0000, 32'h3FC0_0000, 32'h3F2A_AAAB, 3'b000, 28}; // 1/1.5

        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset.ctrl", 32'({bus.busy, bus.done}), 32'h0);
        check("reset.quotient", bus.Quotient, 32'h0);
        check("reset.flags", 32'({bus.overflow, bus.underflow, bus.div_by_zero}), 32'h0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Table of directed vectors
        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat, busy_bad);
            check($sformatf("vec%0d.quotient", i), bus.Quotient, vecs[i].q);
            check($sformatf("vec%0d.flags", i),
                  32'({bus.overflow, bus.underflow, bus.div_by_zero}), 32'(vecs[i].flags));
            check($sformatf("vec%0d.latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d.busy", i), 32'(busy_bad), 32'h0);
            @(posedge clock);
            #1;
            check($sformatf("vec%0d.done_pulse", i), 32'(bus.done), 32'h0);
        end

        // Stray start during DIVIDE is ignored
        bus.A     = 32'h40C0_0000;
        bus.B     = 32'h4000_0000;
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        n = 1;
        while (!bus.done && n < TIMEOUT) begin
            if (n == 10) begin
                bus.start = 1'b1;
                bus.A     = 32'h3F80_0000;
                bus.B     = 32'h4040_0000;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clock);
            #1;
            n++;
        end
        bus.start = 1'b0;
        check("stray_start.latency", 32'(n), 32'd28);
        check("stray_start.quotient", bus.Quotient, 32'h4040_0000);
        @(posedge clock);
        #1;

        // Reset in the middle of a division
        bus.A     = 32'h40C0_0000;
        bus.B     = 32'h4000_0000;
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        n = 1;
        while (n < 15) begin
            @(posedge clock);
            #1;
            n++;
        end
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("mid_reset.ctrl", 32'({bus.busy, bus.done}), 32'h0);
        check("mid_reset.quotient", bus.Quotient, 32'h0);
        check("mid_reset.flags",
              32'({bus.overflow, bus.underflow, bus.div_by_zero}), 32'h0);
        @(posedge clock);
        #1;
        reset     = 1'b1;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus.done || bus.busy) seen_done = 1'b1;
        end
        check("mid_reset.no_done", 32'(seen_done), 32'h0);
        run_op(32'h40C0_0000, 32'h4000_0000, lat, busy_bad);
        check("after_reset.quotient", bus.Quotient, 32'h4040_0000);
        check("after_reset.latency", 32'(lat), 32'd28);
        @(posedge clock);
        #1;

        // Flags from a previous operation clear when the next start is accepted
        run_op(32'h7F7F_FFFF, 32'h3F00_0000, lat, busy_bad);
        check("flag_clear.prev_ovf", 32'(bus.overflow), 32'h1);
        @(posedge clock);
        #1;
        bus.A     = 32'h40C0_0000;
        bus.B     = 32'h4000_0000;
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        check("flag_clear.busy_t1", 32'(bus.busy), 32'h1);
        check("flag_clear.ovf", 32'(bus.overflow), 32'h0);
        n = 1;
        wait_done(n);
        check("flag_clear.quotient", bus.Quotient, 32'h4040_0000);

        // Back-to-back: start held through DONE and the following idle cycle;
        // only the idle cycle may accept it.
        bus.A     = 32'hBF80_0000;
        bus.B     = 32'h4040_0000;
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        check("b2b.done_cleared", 32'(bus.done), 32'h0);
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        n = 2;
        wait_done(n);
        check("b2b.done_to_done", 32'(n), 32'd29);
        check("b2b.quotient", bus.Quotient, 32'hBEAA_AAAB);
        @(posedge clock);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
